// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the mul/div FSM state encoding, default latencies and the register-match helper.
package hazard_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   localparam int MUL_LAT_DEF = 4;
   localparam int DIV_LAT_DEF = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // One bit per pipeline-register control line, pc hold first.
   typedef struct packed {
      logic pc_stall;
      logic ifid_stall;
      logic ifid_flush;
      logic idex_stall;
      logic idex_flush;
      logic exmem_stall;
      logic exmem_flush;
      logic memwb_stall;
      logic memwb_flush;
   } hz_ctrl_t;

   localparam hz_ctrl_t HZ_NONE = '0;

   // True when a used source register matches a producing destination register.
   function automatic logic src_match(input logic       uses,
                                      input logic [4:0] src,
                                      input logic [4:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = pipeline side (drives decode/EX/MEM status), slave = hazard controller.
interface hazard_ctrl_if;

   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic [4:0] ex_rt;
   logic       ex_mem_read;
   logic       ex_branch_taken;
   logic       ex_md_start;
   logic       ex_md_is_div;
   logic       mem_busy;
   logic       exc_flush;

   logic       pc_stall;
   logic       ifid_stall;
   logic       ifid_flush;
   logic       idex_stall;
   logic       idex_flush;
   logic       exmem_stall;
   logic       exmem_flush;
   logic       memwb_stall;
   logic       memwb_flush;
   logic       md_busy;
   logic       md_done;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt,
      output ex_rt, ex_mem_read, ex_branch_taken, ex_md_start, ex_md_is_div,
      output mem_busy, exc_flush,
      input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
      input  exmem_stall, exmem_flush, memwb_stall, memwb_flush,
      input  md_busy, md_done
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt,
      input  ex_rt, ex_mem_read, ex_branch_taken, ex_md_start, ex_md_is_div,
      input  mem_busy, exc_flush,
      output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
      output exmem_stall, exmem_flush, memwb_stall, memwb_flush,
      output md_busy, md_done
   );

endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// Multi-cycle mul/div occupancy timer: IDLE/BUSY FSM with a down-counter.
// md_hold_o requests an EX stall; md_done_o pulses on the cycle the result is taken.
module md_timer
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF,
   parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic md_start_i,
   input  logic md_is_div_i,
   input  logic mem_busy_i,
   input  logic exc_flush_i,
   output logic md_busy_o,
   output logic md_done_o,
   output logic md_hold_o
);

   // The start cycle is itself a stall cycle, so the counter loads LAT-1.
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      md_hold_o = 1'b0;
      md_done_o = 1'b0;
      md_busy_o = (state_q == BUSY);

      unique case (state_q)
         IDLE: begin
            if (md_start_i) begin
               md_hold_o = 1'b1;
               state_d   = BUSY;
               cnt_d     = md_is_div_i ? DIV_LOAD : MUL_LOAD;
            end
         end
         BUSY: begin
            // Counting continues under mem_busy; only the final release waits for memory.
            if (cnt_q != '0) begin
               md_hold_o = 1'b1;
               cnt_d     = cnt_q - CNT_W'(1);
            end else if (mem_busy_i) begin
               md_hold_o = 1'b1;
            end else begin
               md_done_o = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (exc_flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush generator for the 5-stage pipeline: load-use detection,
// branch redirect, mul/div occupancy, data-memory wait and exception flush.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF,
   parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
   input  logic        clk,
   input  logic        rst,
   hazard_ctrl_if.slave bus
);

   logic     load_use;
   logic     md_stall;
   logic     md_busy;
   logic     md_done;
   hz_ctrl_t ctrl;

   md_timer #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT),
      .CNT_W   (CNT_W)
   ) u_md_timer (
      .clk         (clk),
      .rst         (rst),
      .md_start_i  (bus.ex_md_start),
      .md_is_div_i (bus.ex_md_is_div),
      .mem_busy_i  (bus.mem_busy),
      .exc_flush_i (bus.exc_flush),
      .md_busy_o   (md_busy),
      .md_done_o   (md_done),
      .md_hold_o   (md_stall)
   );

   // r0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = bus.ex_mem_read && (bus.ex_rt != REG_ZERO) &&
                     (src_match(bus.id_uses_rs, bus.id_rs, bus.ex_rt) ||
                      src_match(bus.id_uses_rt, bus.id_rt, bus.ex_rt));

   always_comb begin
      ctrl = HZ_NONE;
      if (!rst) begin
         ctrl = HZ_NONE;
      end else if (bus.exc_flush) begin
         ctrl.ifid_flush  = 1'b1;
         ctrl.idex_flush  = 1'b1;
         ctrl.exmem_flush = 1'b1;
      end else if (bus.mem_busy) begin
         ctrl.pc_stall    = 1'b1;
         ctrl.ifid_stall  = 1'b1;
         ctrl.idex_stall  = 1'b1;
         ctrl.exmem_stall = 1'b1;
         ctrl.memwb_stall = 1'b1;
      end else if (md_stall) begin
         // EX is occupied: freeze the front end and feed MEM a bubble.
         ctrl.pc_stall    = 1'b1;
         ctrl.ifid_stall  = 1'b1;
         ctrl.idex_stall  = 1'b1;
         ctrl.exmem_flush = 1'b1;
      end else if (bus.ex_branch_taken) begin
         ctrl.ifid_flush  = 1'b1;
         ctrl.idex_flush  = 1'b1;
      end else if (load_use) begin
         ctrl.pc_stall    = 1'b1;
         ctrl.ifid_stall  = 1'b1;
         ctrl.idex_flush  = 1'b1;
      end
   end

   assign bus.pc_stall    = ctrl.pc_stall;
   assign bus.ifid_stall  = ctrl.ifid_stall;
   assign bus.ifid_flush  = ctrl.ifid_flush;
   assign bus.idex_stall  = ctrl.idex_stall;
   assign bus.idex_flush  = ctrl.idex_flush;
   assign bus.exmem_stall = ctrl.exmem_stall;
   assign bus.exmem_flush = ctrl.exmem_flush;
   assign bus.memwb_stall = ctrl.memwb_stall;
   assign bus.memwb_flush = ctrl.memwb_flush;
   assign bus.md_busy     = rst && md_busy;
   assign bus.md_done     = rst && md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: inputs change at the falling edge,
// outputs are compared 1 ns later against hand-computed control patterns.
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   hazard_ctrl_if bus ();

   hazard_ctrl #(
      .MUL_LAT (4),
      .DIV_LAT (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view of every output, pc_stall in bit 10 down to md_done in bit 0.
   localparam logic [10:0] PC  = 11'd1 << 10;
   localparam logic [10:0] IFS = 11'd1 << 9;
   localparam logic [10:0] IFF = 11'd1 << 8;
   localparam logic [10:0] IDS = 11'd1 << 7;
   localparam logic [10:0] IDF = 11'd1 << 6;
   localparam logic [10:0] EXS = 11'd1 << 5;
   localparam logic [10:0] EXF = 11'd1 << 4;
   localparam logic [10:0] MWS = 11'd1 << 3;
   localparam logic [10:0] BSY = 11'd1 << 1;
   localparam logic [10:0] DN  = 11'd1 << 0;

   localparam logic [10:0] NONE = 11'd0;
   localparam logic [10:0] LU   = PC | IFS | IDF;
   localparam logic [10:0] BR   = IFF | IDF;
   localparam logic [10:0] MB   = PC | IFS | IDS | EXS | MWS;
   localparam logic [10:0] MD   = PC | IFS | IDS | EXF;
   localparam logic [10:0] EXC  = IFF | IDF | EXF;

   logic [10:0] outs;
   assign outs = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_stall,
                  bus.idex_flush, bus.exmem_stall, bus.exmem_flush, bus.memwb_stall,
                  bus.memwb_flush, bus.md_busy, bus.md_done};

   always @(negedge clk) begin
      assert (!(bus.ex_branch_taken && bus.ex_md_start))
         else $error("branch and mul/div start driven together");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   task automatic clear_inputs();
      bus.id_rs           = 5'd0;
      bus.id_rt           = 5'd0;
      bus.id_uses_rs      = 1'b0;
      bus.id_uses_rt      = 1'b0;
      bus.ex_rt           = 5'd0;
      bus.ex_mem_read     = 1'b0;
      bus.ex_branch_taken = 1'b0;
      bus.ex_md_start     = 1'b0;
      bus.ex_md_is_div    = 1'b0;
      bus.mem_busy        = 1'b0;
      bus.exc_flush       = 1'b0;
   endtask

   // Holds ex_md_start for lat cycles, optionally stretches the cnt==0 cycle
   // with mb_cycles of mem_busy, then expects exactly one md_done.
   task automatic run_md(input string tag, input int lat, input logic is_div, input int mb_cycles);
      @(negedge clk);
      bus.ex_md_start  = 1'b1;
      bus.ex_md_is_div = is_div;
      #1 chk({tag, "_c0"}, outs, MD);
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         #1 chk($sformatf("%s_c%0d", tag, i), outs, MD | BSY);
      end
      for (int j = 0; j < mb_cycles; j++) begin
         @(negedge clk);
         bus.mem_busy = 1'b1;
         #1 chk($sformatf("%s_memwait%0d", tag, j), outs, MB | BSY);
      end
      @(negedge clk);
      bus.mem_busy = 1'b0;
      #1 chk({tag, "_done"}, outs, BSY | DN);
      @(negedge clk);
      bus.ex_md_start  = 1'b0;
      bus.ex_md_is_div = 1'b0;
      #1 chk({tag, "_after"}, outs, NONE);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      clear_inputs();
      rst = 1'b0;

      // Reset must mask even active hazard inputs.
      @(negedge clk);
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b1;
      bus.mem_busy = 1'b1;
      #1 chk("reset_masks", outs, NONE);
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      #1 chk("idle", outs, NONE);

      @(negedge clk);
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b1;
      #1 chk("lu_rs", outs, LU);
      @(negedge clk);
      bus.id_uses_rs = 1'b0;
      #1 chk("lu_rs_unused", outs, NONE);
      @(negedge clk);
      bus.id_rs = 5'd3; bus.id_uses_rs = 1'b1; bus.id_rt = 5'd8; bus.id_uses_rt = 1'b1;
      #1 chk("lu_rt", outs, LU);
      @(negedge clk);
      bus.ex_mem_read = 1'b0;
      #1 chk("lu_no_load", outs, NONE);
      @(negedge clk);
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
      #1 chk("lu_r0", outs, NONE);
      @(negedge clk);
      bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.ex_branch_taken = 1'b1;
      #1 chk("branch_over_lu", outs, BR);
      @(negedge clk);
      bus.mem_busy = 1'b1;
      #1 chk("membusy_over_branch", outs, MB);
      @(negedge clk);
      bus.exc_flush = 1'b1;
      #1 chk("exc_over_all", outs, EXC);
      @(negedge clk);
      clear_inputs();
      #1 chk("cleared", outs, NONE);

      run_md("mul", 4, 1'b0, 0);
      run_md("div", 32, 1'b1, 0);
      run_md("divmem", 32, 1'b1, 3);

      // Exception in the middle of a divide abandons it without md_done.
      @(negedge clk);
      bus.ex_md_start = 1'b1; bus.ex_md_is_div = 1'b1;
      #1 chk("exc_div_c0", outs, MD);
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         #1 chk($sformatf("exc_div_c%0d", i), outs, MD | BSY);
      end
      @(negedge clk);
      bus.exc_flush = 1'b1;
      #1 chk("exc_div_flush", outs, EXC | BSY);
      @(negedge clk);
      clear_inputs();
      #1 chk("exc_div_idle", outs, NONE);
      @(negedge clk);
      #1 chk("exc_div_quiet", outs, NONE);

      // Asynchronous reset while BUSY.
      @(negedge clk);
      bus.ex_md_start = 1'b1;
      #1 chk("rstbusy_c0", outs, MD);
      @(negedge clk);
      #1 chk("rstbusy_c1", outs, MD | BSY);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("rstbusy_now", outs, NONE);
      @(negedge clk);
      clear_inputs();
      #1 chk("rstbusy_held", outs, NONE);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rstbusy_release", outs, NONE);

      // Asynchronous reset while a finished multiply waits on memory.
      @(negedge clk);
      bus.ex_md_start = 1'b1;
      #1 chk("rstmem_c0", outs, MD);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         #1 chk($sformatf("rstmem_c%0d", i), outs, MD | BSY);
      end
      @(negedge clk);
      bus.mem_busy = 1'b1;
      #1 chk("rstmem_wait", outs, MB | BSY);
      #1 rst = 1'b0;
      #1 chk("rstmem_now", outs, NONE);
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      #1 chk("rstmem_release", outs, NONE);

      run_md("mul2", 4, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
